// File: rtl/fixed_point_pkg.sv
// ---------------------------------------------------------------------------
// fixed_point_pkg : shared defaults, width helpers and saturation constants
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fixed_point_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_DEC_POINT_POS = 4;

  // Signed exponent difference; generous so no realistic parameter set overflows
  localparam int SHIFT_W = 16;

  // Saturation values are built at this width, then truncated by the user
  localparam int MAX_R_W = 64;

  // Fraction bits kept below the leading one
  function automatic int frac_w(input int width);
    return width - 2;
  endfunction

  // Largest positive two's-complement value of the given width
  function automatic logic [MAX_R_W-1:0] sat_pos(input int width);
    return (MAX_R_W'(1) << (width - 1)) - MAX_R_W'(1);
  endfunction

  // Symmetric negative saturation: -(2^(width-1)-1)
  function automatic logic [MAX_R_W-1:0] sat_neg(input int width);
    return ~sat_pos(width) + MAX_R_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_lod.sv
// ---------------------------------------------------------------------------
// div_lod : priority leading-one detector, returns index of the highest set bit
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_lod #(
  parameter int IN_W  = 7,
  parameter int POS_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  din,
  output logic [POS_W-1:0] pos
);

  // Later iterations win, so the highest set bit sets the result; zero input gives 0
  always_comb begin
    pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (din[i]) pos = POS_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fixed_int_div.sv
// ---------------------------------------------------------------------------
// fixed_int_div : 3-stage Mitchell-approximation signed fixed-point divider
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fixed_int_div
  import fixed_point_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEC_POINT_POS = DEF_DEC_POINT_POS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-3:0]     Conf_Bit_Mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   R,
  output logic                 dz,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int F_W   = frac_w(WIDTH);
  localparam int MAG_W = WIDTH - 1;
  localparam int POS_W = $clog2(MAG_W);
  localparam int M_W   = F_W + 2;
  localparam int R_W   = 2 * WIDTH;

  localparam logic [MAG_W-1:0] MAG_SAT   = MAG_W'(sat_pos(WIDTH));
  localparam logic [R_W-1:0]   R_SAT_POS = R_W'(sat_pos(R_W));
  localparam logic [R_W-1:0]   R_SAT_NEG = R_W'(sat_neg(R_W));

  // ---------------------------------------------------------------- handshake
  logic s1_valid;
  logic s2_valid;
  logic s3_free;
  logic s2_free;
  logic s1_free;

  assign s3_free  = !out_valid || out_ready;
  assign s2_free  = !s2_valid  || s3_free;
  assign s1_free  = !s1_valid  || s2_free;
  assign in_ready = s1_free;

  // ---------------------------------------------------------------- stage 1
  function automatic logic [MAG_W-1:0] abs_sat(input logic [WIDTH-1:0] v);
    if (!v[WIDTH-1])           return v[MAG_W-1:0];
    if (v[MAG_W-1:0] == '0)    return MAG_SAT;
    return MAG_W'(-v);
  endfunction

  // Shift the leading one up to bit F_W; the bits beneath it are the fraction
  function automatic logic [F_W-1:0] norm_frac(input logic [MAG_W-1:0] mag,
                                               input logic [POS_W-1:0] k);
    logic [MAG_W-1:0] shifted;
    shifted = mag << (POS_W'(F_W) - k);
    return shifted[F_W-1:0];
  endfunction

  logic [MAG_W-1:0] mag_a;
  logic [MAG_W-1:0] mag_b;
  logic [POS_W-1:0] ka;
  logic [POS_W-1:0] kb;

  assign mag_a = abs_sat(A);
  assign mag_b = abs_sat(B);

  div_lod #(.IN_W(MAG_W), .POS_W(POS_W)) u_lod_a (.din(mag_a), .pos(ka));
  div_lod #(.IN_W(MAG_W), .POS_W(POS_W)) u_lod_b (.din(mag_b), .pos(kb));

  logic             s1_sign;
  logic             s1_a_neg;
  logic             s1_a_zero;
  logic             s1_b_zero;
  logic [POS_W-1:0] s1_ka;
  logic [POS_W-1:0] s1_kb;
  logic [F_W-1:0]   s1_fa;
  logic [F_W-1:0]   s1_fb;
  logic [F_W-1:0]   s1_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_a_neg  <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_ka     <= '0;
      s1_kb     <= '0;
      s1_fa     <= '0;
      s1_fb     <= '0;
      s1_mask   <= '0;
    end else if (s1_free) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= A[WIDTH-1] ^ B[WIDTH-1];
        s1_a_neg  <= A[WIDTH-1];
        s1_a_zero <= (A == '0);
        s1_b_zero <= (B == '0);
        s1_ka     <= ka;
        s1_kb     <= kb;
        s1_fa     <= norm_frac(mag_a, ka);
        s1_fb     <= norm_frac(mag_b, kb);
        s1_mask   <= Conf_Bit_Mask;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [F_W-1:0]             fa_m;
  logic [F_W-1:0]             fb_m;
  logic [M_W-1:0]             m_c;
  logic signed [SHIFT_W-1:0]  s_c;

  // Mitchell: log2 ratio = (ka+fa) - (kb+fb); a borrow moves one octave down
  always_comb begin
    fa_m = s1_fa & s1_mask;
    fb_m = s1_fb & s1_mask;
    s_c  = SHIFT_W'(s1_ka) - SHIFT_W'(s1_kb)
         + SHIFT_W'(DEC_POINT_POS) - SHIFT_W'(F_W);
    if (fa_m >= fb_m) begin
      m_c = {2'b01, fa_m} - {2'b00, fb_m};
    end else begin
      m_c = {2'b10, fa_m} - {2'b00, fb_m};
      s_c = s_c - SHIFT_W'(1);
    end
  end

  logic                      s2_sign;
  logic                      s2_a_neg;
  logic                      s2_a_zero;
  logic                      s2_b_zero;
  logic [M_W-1:0]            s2_m;
  logic signed [SHIFT_W-1:0] s2_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_a_neg  <= 1'b0;
      s2_a_zero <= 1'b0;
      s2_b_zero <= 1'b0;
      s2_m      <= '0;
      s2_s      <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign   <= s1_sign;
        s2_a_neg  <= s1_a_neg;
        s2_a_zero <= s1_a_zero;
        s2_b_zero <= s1_b_zero;
        s2_m      <= m_c;
        s2_s      <= s_c;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [SHIFT_W-1:0] neg_s;
  logic [R_W-1:0]     mag_c;
  logic [R_W-1:0]     r_c;

  always_comb begin
    neg_s = -s2_s;
    if (!s2_s[SHIFT_W-1]) mag_c = R_W'(s2_m) << s2_s;
    else                  mag_c = R_W'(s2_m) >> neg_s;
    r_c = s2_sign ? -mag_c : mag_c;
    if (s2_b_zero)      r_c = s2_a_neg ? R_SAT_NEG : R_SAT_POS;
    else if (s2_a_zero) r_c = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      R         <= '0;
      dz        <= 1'b0;
    end else if (s3_free) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        R  <= r_c;
        dz <= s2_b_zero;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_int_div.sv
// ---------------------------------------------------------------------------
// tb_fixed_int_div : scoreboard bench for fixed_int_div (WIDTH=8, DEC_POINT_POS=4)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fixed_int_div;

  localparam int WIDTH = 8;
  localparam int DEC   = 4;
  localparam int F     = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [5:0]  mask;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] R;
  logic        dz;
  logic        out_valid;
  logic        out_ready;

  fixed_int_div #(.WIDTH(WIDTH), .DEC_POINT_POS(DEC)) dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .Conf_Bit_Mask (mask),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .R             (R),
    .dz            (dz),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic        dz;
    int          t;
    bit          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc   = 0;
  int   nid   = 0;
  bit   rnd_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent Mitchell reference: returns {dz, R}
  function automatic logic [16:0] model(input int a, input int b, input logic [5:0] m);
    int ma, mb, ka, kb, fa, fb, mm, s, mag, r;
    if (b == 0) return {1'b1, (a < 0) ? 16'h8001 : 16'h7FFF};
    if (a == 0) return 17'd0;
    ma = (a < 0) ? ((a == -128) ? 127 : -a) : a;
    mb = (b < 0) ? ((b == -128) ? 127 : -b) : b;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 7; i++) begin
      if (ma >= (1 << i)) ka = i;
      if (mb >= (1 << i)) kb = i;
    end
    fa = (((ma - (1 << ka)) << F) >> ka) & int'(m);
    fb = (((mb - (1 << kb)) << F) >> kb) & int'(m);
    if (fa >= fb) begin
      mm = 64 + fa - fb;
      s  = ka - kb + DEC - F;
    end else begin
      mm = 128 + fa - fb;
      s  = ka - kb + DEC - F - 1;
    end
    mag = (s >= 0) ? (mm << s) : (mm >> (-s));
    mag = mag & 32'hFFFF;
    r   = ((a < 0) != (b < 0)) ? -mag : mag;
    return {1'b0, 16'(r)};
  endfunction

  // Monitor: pops the scoreboard on each output transfer, checks holds during stalls
  exp_t        mon_e;
  logic [15:0] prev_r;
  logic        prev_dz;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_r", {16'd0, R}, {16'd0, prev_r});
        check("hold_dz", {31'd0, dz}, {31'd0, prev_dz});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("r_%0d", mon_e.id), {16'd0, R}, {16'd0, mon_e.r});
          check($sformatf("dz_%0d", mon_e.id), {31'd0, dz}, {31'd0, mon_e.dz});
          if (mon_e.lat)
            check($sformatf("latency_%0d", mon_e.id), cyc - mon_e.t, 32'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = R;
      prev_dz    = dz;
    end
  end

  // Called just after a rising edge; returns just after the transfer edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [5:0] m,
                      input logic [15:0] er, input logic edz, input bit lat, input bit nowait);
    int   w;
    exp_t e;
    A        = a;
    B        = b;
    mask     = m;
    in_valid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    nid++;
    if (!in_ready) begin
      check($sformatf("in_ready_timeout_%0d", nid), 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (nowait) check($sformatf("throughput_%0d", nid), w, 32'd0);
      e.r   = er;
      e.dz  = edz;
      e.t   = cyc;
      e.lat = lat;
      e.id  = nid;
      sb.push_back(e);
      acc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_mod(input logic [7:0] a, input logic [7:0] b, input logic [5:0] m,
                          input bit nowait);
    logic [16:0] x;
    x = model(int'($signed(a)), int'($signed(b)), m);
    send(a, b, m, x[15:0], x[16], 1'b0, nowait);
  endtask

  task automatic idle();
    int w;
    in_valid = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    mask      = 6'h3F;
    out_ready = 1'b1;
    #1;
    check("rst_r", {16'd0, R}, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors with hand-derived results, latency checked on each
    send(8'd6,   8'd3,   6'h3F, 16'h0020, 1'b0, 1'b1, 1'b0); idle();
    send(8'd7,   8'd5,   6'h3F, 16'h0018, 1'b0, 1'b1, 1'b0); idle();
    send(8'd3,   8'd7,   6'h3F, 16'h0007, 1'b0, 1'b1, 1'b0); idle();
    send(8'hFA,  8'd3,   6'h3F, 16'hFFE0, 1'b0, 1'b1, 1'b0); idle();
    send(8'd100, 8'd0,   6'h3F, 16'h7FFF, 1'b1, 1'b1, 1'b0); idle();
    send(8'hFB,  8'd0,   6'h3F, 16'h8001, 1'b1, 1'b1, 1'b0); idle();
    send(8'd0,   8'd9,   6'h3F, 16'h0000, 1'b0, 1'b1, 1'b0); idle();
    send(8'd0,   8'd0,   6'h3F, 16'h7FFF, 1'b1, 1'b1, 1'b0); idle();
    send(8'd0,   8'hFD,  6'h3F, 16'h0000, 1'b0, 1'b1, 1'b0); idle();
    send(8'h80,  8'd3,   6'h3F, 16'hFD08, 1'b0, 1'b1, 1'b0); idle();
    send(8'd127, 8'd1,   6'h3F, 16'h07F0, 1'b0, 1'b1, 1'b0); idle();
    send(8'd127, 8'd1,   6'h38, 16'h0780, 1'b0, 1'b1, 1'b0); idle();
    send(8'd9,   8'd7,   6'h38, 16'h0016, 1'b0, 1'b1, 1'b0); idle();

    // Back-to-back stream: must be accepted every cycle
    send_mod(8'd12,  8'd5,   6'h3F, 1'b1);
    send_mod(8'hF1,  8'd9,   6'h3F, 1'b1);
    send_mod(8'd77,  8'hE3,  6'h38, 1'b1);
    send_mod(8'h80,  8'h80,  6'h3F, 1'b1);
    send_mod(8'd1,   8'd127, 6'h3F, 1'b1);
    send_mod(8'd55,  8'd0,   6'h3F, 1'b1);
    send_mod(8'hC4,  8'd3,   6'h2A, 1'b1);
    send_mod(8'd127, 8'h80,  6'h3F, 1'b1);
    idle();

    // Output stall: three accepted, then back-pressure, then ordered drain
    out_ready = 1'b0;
    acc       = 0;
    fork
      begin
        send_mod(8'd20, 8'd3, 6'h3F, 1'b0);
        send_mod(8'd21, 8'd4, 6'h3F, 1'b0);
        send_mod(8'd22, 8'd5, 6'h3F, 1'b0);
        send_mod(8'd23, 8'd6, 6'h3F, 1'b0);
        send_mod(8'd24, 8'd7, 6'h3F, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_accepted", acc, 32'd3);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle();

    // Reset with two transactions in flight
    send_mod(8'd40, 8'd3, 6'h3F, 1'b0);
    send_mod(8'd41, 8'd5, 6'h3F, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_r", {16'd0, R}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);

    // Random operands with random back-pressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] ra, rb;
          logic [5:0] rm;
          ra = 8'($urandom);
          rb = 8'($urandom);
          if (i % 10 == 3) ra = 8'h80;
          if (i % 13 == 5) rb = 8'h00;
          case ($urandom_range(0, 2))
            0:       rm = 6'h3F;
            1:       rm = 6'h38;
            default: rm = 6'($urandom);
          endcase
          send_mod(ra, rb, rm, 1'b0);
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle();
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
